tqvp_spi_target: RTL and testbench
==================================

# tqvp_spi_target

SPI target (slave) for TinyQV user peripherals: the far end of the team's SPI controller, letting an external SPI controller exchange bytes with the core. External SCLK, CS and MOSI are oversampled and synchronised into the `clk` domain; the block runs SPI mode 0 only, MSB first. Received bytes are presented to a register interface, and transmit bytes are pre-loaded for the next exchange.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop depth of each input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- spi_cs_n  in  1  external chip select, active-low, asynchronous to clk
- spi_sclk  in  1  external SPI clock, asynchronous to clk
- spi_mosi  in  1  external data in
- spi_miso  out  1  data out
- spi_miso_oe  out  1  high while the target is selected (synchronised CS low)
- tx_data  in  8  next byte to transmit
- tx_write  in  1  1-cycle strobe that loads tx_data into the tx holding register
- tx_full  out  1  tx holding register occupied
- rx_data  out  8  oldest received byte
- rx_valid  out  1  rx_data holds an unread byte
- rx_read  in  1  1-cycle strobe that pops rx_data (ignored when rx_valid is low)
- rx_overrun  out  1  sticky: a byte completed while rx storage was full
- tx_underrun  out  1  sticky: a byte started with tx holding register empty
- clear_flags  in  1  clears both sticky flags
- selected  out  1  synchronised CS active

## Operation
- Reset: spi_miso=1, spi_miso_oe=0, tx_full=0, rx_valid=0, rx_data=0, rx_overrun=0, tx_underrun=0, selected=0, bit counter=0. Synchroniser flops reset to idle (CS=1, SCLK=0).
- States: IDLE (CS high) and ACTIVE (CS low). Bit counter is 3 bits and wraps 7->0 at each byte boundary.
- On a detected CS falling edge, or on a byte boundary while ACTIVE, the byte starts:
  - If tx_full: the shift register loads tx_data_hold and tx_full clears.
  - Otherwise: the shift register loads 0xFF and tx_underrun is set.
  - spi_miso = shift register bit 7.
- On a detected SCLK rising edge while ACTIVE: the synchronised MOSI is shifted into the rx shift register LSB and the counter increments.
- On a detected SCLK falling edge while ACTIVE: the tx shift register shifts left and spi_miso updates. The falling edge that follows the 8th rising edge instead performs the byte-boundary load.
- After the 8th rising edge, the received byte is written to rx storage.
  - If storage is full, the byte is dropped and rx_overrun is set. Existing contents are kept.
- A CS rising edge mid-byte discards the partial rx byte and resets the counter. A tx byte already loaded into the shift register is consumed and is not restored. spi_miso_oe drops.
- tx_write while tx_full overwrites the holding register (last write wins) and sets no flag.
- Simultaneous events:
  - rx_read and a byte completion in the same cycle with storage full: the pop happens first, the new byte is stored, no overrun.
  - tx_write and a byte start in the same cycle: the start consumes the old contents (or 0xFF), and the new data is held with tx_full=1.
  - clear_flags and a flag-setting event in the same cycle: the flag ends set.

## Timing
- Input path latency: SYNC_STAGES flops plus 1 edge-detect register, i.e. 3 clk with the default.
- rx_valid rises 1 clk after the 8th SCLK rising edge is detected.
- spi_miso changes 1 clk after the SCLK falling edge is detected (4 clk after the pin with the default). Controller must sample on the rising edge.
- SCLK high and low phases must each be at least SYNC_STAGES+3 clk. CS setup before the first SCLK rise must be at least SYNC_STAGES+3 clk. Faster SCLK is unsupported and gives undefined data, but must not hang the block.
- rx_read pops in the same cycle; the next byte (if any) appears on rx_data the following clk.

## Configuration
- SPI_TARGET_RX_FIFO_EN defined: rx storage is a 4-entry FIFO (2-bit pointers plus a 3-bit count). rx_valid = count != 0. Overrun occurs when count == 4.
- Not defined: rx storage is a single holding register. Overrun occurs when rx_valid=1 at byte completion.

## Structure
- Shared package tqvp_spi_pkg: SPI_MODE0 constant, TX_IDLE_BYTE = 8'hFF, RX_FIFO_DEPTH = 4.
- One sub-module, tqvp_spi_target_sync: a SYNC_STAGES synchroniser plus rise/fall edge detector, instantiated once each for SCLK and CS. MOSI uses a plain synchroniser of matched depth.

## Test plan
- Preload 0xA5 via tx_write, controller sends 0x3C at SCLK = clk/16 -> MISO captures 0xA5, rx_data=0x3C, rx_valid=1, tx_full=0, no flags.
- Two back-to-back bytes 0x11, 0x22 without reading, no FIFO -> rx_data=0x11, rx_overrun=1. With SPI_TARGET_RX_FIFO_EN -> pops return 0x11 then 0x22, no overrun.
- Exchange with nothing preloaded -> MISO returns 0xFF, tx_underrun=1. Then clear_flags -> flag returns to 0.
- CS deasserted after 5 bits, then a full byte 0x81 -> rx_data=0x81 only, counter realigned, exactly one rx_valid.
- rstn asserted mid-byte -> all outputs at reset values next clk. Next full transaction with preload 0x5A/0xC3 completes correctly.
- rx_read coincident with byte completion, storage full -> no overrun, new byte readable next.

Source files
------------

// File: rtl/tqvp_spi_target_pkg.sv
// Shared constants and state type for the TinyQV SPI target.
package tqvp_spi_pkg;

  localparam logic [1:0] SPI_MODE0     = 2'd0;
  localparam logic [7:0] TX_IDLE_BYTE  = 8'hFF;
  localparam int         RX_FIFO_DEPTH = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/tqvp_spi_target_sync.sv
// Multi-flop synchroniser for an external pin followed by a registered
// rise/fall detector; edge pulses appear SYNC_STAGES+1 clk after the pin moves.
module tqvp_spi_target_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   level;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      level <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~level;
      fall  <= ~chain[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/tqvp_spi_target.sv
// SPI mode-0 target for TinyQV peripherals, MSB first, oversampled in clk.
// Define SPI_TARGET_RX_FIFO_EN for a 4-entry rx FIFO instead of one holding register.
module tqvp_spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_write,
  output logic       tx_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  output logic       rx_overrun,
  output logic       tx_underrun,
  input  logic       clear_flags,
  output logic       selected
);
  import tqvp_spi_pkg::*;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  tqvp_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rstn(rstn), .din(spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  tqvp_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rstn(rstn), .din(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk) begin
    if (!rstn) mosi_chain <= '0;
    else       mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  spi_state_t state, state_next;
  logic [2:0] bit_cnt;
  logic       boundary;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic [7:0] tx_shift;
  logic [7:0] tx_hold;
  logic       byte_start, rx_shift_en, tx_shift_en, byte_done;
  logic       rx_pop, rx_full_eff;

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A CS rise wins over any SCLK edge in the same cycle, so a final SCLK
  // fall coincident with deselect does not start (and consume) another byte.
  always_comb begin
    state_next  = state;
    byte_start  = 1'b0;
    rx_shift_en = 1'b0;
    tx_shift_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next = ST_ACTIVE;
          byte_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
        end else begin
          if (sclk_rise) rx_shift_en = 1'b1;
          if (sclk_fall) begin
            if (boundary) byte_start  = 1'b1;
            else          tx_shift_en = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rx_byte   = {rx_shift, mosi_s};
  assign byte_done = rx_shift_en && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_cnt     <= '0;
      boundary    <= 1'b0;
      rx_shift    <= '0;
      tx_shift    <= TX_IDLE_BYTE;
      tx_hold     <= '0;
      tx_full     <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      if (state != ST_ACTIVE || cs_rise) begin
        bit_cnt  <= '0;
        boundary <= 1'b0;
        rx_shift <= '0;
      end else if (rx_shift_en) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        boundary <= (bit_cnt == 3'd7);
      end else if (byte_start) begin
        boundary <= 1'b0;
      end

      if (byte_start)       tx_shift <= tx_full ? tx_hold : TX_IDLE_BYTE;
      else if (tx_shift_en) tx_shift <= {tx_shift[6:0], 1'b1};

      if (tx_write) tx_hold <= tx_data;
      tx_full     <= tx_write | (tx_full & ~byte_start);
      tx_underrun <= (byte_start & ~tx_full) | (tx_underrun & ~clear_flags);
      rx_overrun  <= (byte_done & rx_full_eff) | (rx_overrun & ~clear_flags);
    end
  end

  assign rx_pop = rx_read & rx_valid;

`ifdef SPI_TARGET_RX_FIFO_EN
  logic [7:0] rx_mem [RX_FIFO_DEPTH];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       rx_push;

  assign rx_full_eff = (count == 3'(RX_FIFO_DEPTH)) & ~rx_pop;
  assign rx_push     = byte_done & ~rx_full_eff;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) rx_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[wr_ptr] <= rx_byte;
        wr_ptr         <= wr_ptr + 2'd1;
      end
      if (rx_pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, rx_push} - {2'b00, rx_pop};
    end
  end

  assign rx_data  = rx_mem[rd_ptr];
  assign rx_valid = (count != 3'd0);
`else
  logic [7:0] rx_hold;
  logic       rx_hold_valid;

  assign rx_full_eff = rx_hold_valid & ~rx_pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_hold       <= '0;
      rx_hold_valid <= 1'b0;
    end else if (byte_done && !rx_full_eff) begin
      rx_hold       <= rx_byte;
      rx_hold_valid <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_valid <= 1'b0;
    end
  end

  assign rx_data  = rx_hold;
  assign rx_valid = rx_hold_valid;
`endif

  assign spi_miso    = tx_shift[7];
  assign selected    = (state == ST_ACTIVE);
  assign spi_miso_oe = selected;

endmodule

// File: tb/tb_tqvp_spi_target.sv
// Self-checking bench for tqvp_spi_target: bit-banged SPI controller plus a
// transaction-level model of tx holding, rx storage and the sticky flags.
module tb_tqvp_spi_target;

  localparam int HALF = 8;
`ifdef SPI_TARGET_RX_FIFO_EN
  localparam int RX_DEPTH = 4;
`else
  localparam int RX_DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_write = 1'b0;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read = 1'b0;
  logic       rx_overrun, tx_underrun;
  logic       clear_flags = 1'b0;
  logic       selected;

  tqvp_spi_target dut (
    .clk(clk), .rstn(rstn), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
    .clear_flags(clear_flags), .selected(selected)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model state
  logic [7:0] m_rxq[$];
  logic [7:0] m_hold = 8'h00;
  bit         m_full = 0, m_ovr = 0, m_und = 0;
  bit         settled = 0;

  logic [7:0] f_mosi [4];
  logic [7:0] last_miso;
  int         rxv_rises = 0;
  logic       rxv_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_byte_start();
    if (m_full) begin
      m_full = 0;
      return m_hold;
    end
    m_und = 1;
    return 8'hFF;
  endfunction

  function automatic void m_byte_done(input logic [7:0] b);
    if (m_rxq.size() < RX_DEPTH) m_rxq.push_back(b);
    else                         m_ovr = 1;
  endfunction

  function automatic void m_pop();
    if (m_rxq.size() != 0) void'(m_rxq.pop_front());
  endfunction

  function automatic void m_reset();
    m_rxq.delete();
    m_full = 0; m_ovr = 0; m_und = 0;
  endfunction

  always @(negedge clk) begin
    if (rx_valid && !rxv_q) rxv_rises++;
    rxv_q = rx_valid;
    if (rstn) chk("oe_vs_selected", spi_miso_oe, selected);
    if (settled) begin
      chk("rx_valid", rx_valid, m_rxq.size() != 0);
      if (m_rxq.size() != 0) chk("rx_data", rx_data, m_rxq[0]);
      chk("tx_full", tx_full, m_full);
      chk("rx_overrun", rx_overrun, m_ovr);
      chk("tx_underrun", tx_underrun, m_und);
      chk("selected_idle", selected, 1'b0);
    end
  end

  task automatic do_write(input logic [7:0] v);
    settled = 0;
    @(negedge clk); tx_data = v; tx_write = 1'b1;
    @(posedge clk); #1 tx_write = 1'b0;
    m_hold = v; m_full = 1;
    @(negedge clk); settled = 1;
  endtask

  task automatic do_read();
    settled = 0;
    @(negedge clk); rx_read = 1'b1;
    @(posedge clk); #1 rx_read = 1'b0;
    m_pop();
    @(negedge clk); settled = 1;
  endtask

  task automatic do_clear();
    settled = 0;
    @(negedge clk); clear_flags = 1'b1;
    @(posedge clk); #1 clear_flags = 1'b0;
    m_ovr = 0; m_und = 0;
    @(negedge clk); settled = 1;
  endtask

  // Clocks nbits of one byte; SCLK changes only on clk negedges. With 'last'
  // the final SCLK fall and the CS rise happen together.
  task automatic spi_byte(input logic [7:0] mosi_b, input int nbits, input bit last,
                          input bit wr_mid, input logic [7:0] wr_val, input bit rd_coinc,
                          output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_b[7-i];
      repeat (HALF) @(negedge clk);
      miso_b[7-i] = spi_miso;
      spi_sclk = 1'b1;
      if (i == 7 && rd_coinc) begin
        repeat (3) @(negedge clk);
        rx_read = 1'b1;
        @(posedge clk); #1 rx_read = 1'b0;
        m_pop();
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      spi_sclk = 1'b0;
      if (i == nbits - 1 && last) spi_cs_n = 1'b1;
      if (i == 3 && wr_mid) begin
        tx_data = wr_val; tx_write = 1'b1;
        @(posedge clk); #1 tx_write = 1'b0;
        m_hold = wr_val; m_full = 1;
      end
    end
    if (nbits == 8) m_byte_done(mosi_b);
  endtask

  task automatic spi_frame(input int nbytes, input int last_bits, input bit wr_mid,
                           input logic [7:0] wr_val, input bit rd_coinc);
    logic [7:0] exp, got, mask;
    settled = 0;
    @(negedge clk); spi_cs_n = 1'b0;
    exp = m_byte_start();
    repeat (HALF) @(negedge clk);
    chk("selected_active", selected, 1'b1);
    for (int b = 0; b < nbytes; b++) begin
      int nb;
      bit lst;
      nb  = (b == nbytes - 1) ? last_bits : 8;
      lst = (b == nbytes - 1) && (nb == 8);
      spi_byte(f_mosi[b], nb, lst, wr_mid && b == 0, wr_val,
               rd_coinc && b == nbytes - 1, got);
      mask = 8'hFF << (8 - nb);
      chk("miso_byte", got, exp & mask);
      last_miso = got;
      if (nb == 8 && !lst) exp = m_byte_start();
    end
    if (last_bits != 8) begin
      repeat (HALF) @(negedge clk);
      spi_cs_n = 1'b1;
    end
    repeat (8) @(negedge clk);
    settled = 1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_miso"}, spi_miso, 1'b1);
    chk({tag, "_oe"}, spi_miso_oe, 1'b0);
    chk({tag, "_tx_full"}, tx_full, 1'b0);
    chk({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk({tag, "_rx_data"}, rx_data, 8'h00);
    chk({tag, "_ovr"}, rx_overrun, 1'b0);
    chk({tag, "_und"}, tx_underrun, 1'b0);
    chk({tag, "_selected"}, selected, 1'b0);
  endtask

  initial begin
    int r0;
    logic [7:0] exp_head;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    settled = 1;

    // preload 0xA5, controller sends 0x3C
    do_write(8'hA5);
    f_mosi[0] = 8'h3C;
    spi_frame(1, 8, 0, 8'h00, 0);
    chk("t1_miso", last_miso, 8'hA5);
    chk("t1_rx_data", rx_data, 8'h3C);
    chk("t1_rx_valid", rx_valid, 1'b1);
    chk("t1_tx_full", tx_full, 1'b0);
    chk("t1_flags", {rx_overrun, tx_underrun}, 2'b00);
    do_read();

    // back-to-back bytes without reading
    f_mosi[0] = 8'h11; f_mosi[1] = 8'h22;
    spi_frame(2, 8, 0, 8'h00, 0);
    chk("t2_rx_data", rx_data, 8'h11);
    chk("t2_ovr", rx_overrun, RX_DEPTH == 1);
    do_read();
    chk("t2_valid_after_pop", rx_valid, RX_DEPTH > 1);
    while (m_rxq.size() != 0) do_read();
    do_clear();

    // nothing preloaded
    f_mosi[0] = 8'h5E;
    spi_frame(1, 8, 0, 8'h00, 0);
    chk("t3_miso", last_miso, 8'hFF);
    chk("t3_und", tx_underrun, 1'b1);
    do_clear();
    chk("t3_und_cleared", tx_underrun, 1'b0);
    do_read();

    // aborted 5-bit byte then full 0x81
    r0 = rxv_rises;
    f_mosi[0] = 8'hFF;
    spi_frame(1, 5, 0, 8'h00, 0);
    f_mosi[0] = 8'h81;
    spi_frame(1, 8, 0, 8'h00, 0);
    chk("t4_rx_data", rx_data, 8'h81);
    chk("t4_valid_rises", rxv_rises - r0, 1);
    do_read();
    do_clear();

    // reset mid-byte
    do_write(8'h77);
    settled = 0;
    @(negedge clk); spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_byte(8'hF0, 3, 0, 0, 8'h00, 0, last_miso);
    rstn = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    rstn = 1'b1;
    m_reset();
    repeat (4) @(negedge clk);
    settled = 1;
    do_write(8'h5A);
    f_mosi[0] = 8'hC3;
    spi_frame(1, 8, 0, 8'h00, 0);
    chk("t5_miso", last_miso, 8'h5A);
    chk("t5_rx_data", rx_data, 8'hC3);

    // rx_read coincident with completion while storage full
    while (m_rxq.size() != 0) do_read();
    do_clear();
    for (int i = 0; i < RX_DEPTH; i++) f_mosi[i] = 8'h10 + 8'(i);
    spi_frame(RX_DEPTH, 8, 0, 8'h00, 0);
    f_mosi[0] = 8'h20;
    spi_frame(1, 8, 0, 8'h00, 1);
    exp_head = (RX_DEPTH == 1) ? 8'h20 : 8'h11;
    chk("t6_ovr", rx_overrun, 1'b0);
    chk("t6_valid", rx_valid, 1'b1);
    chk("t6_head", rx_data, exp_head);
    while (m_rxq.size() != 0) do_read();
    do_clear();

    // randomized frames
    for (int it = 0; it < 30; it++) begin
      int nbytes, lbits, nrd;
      if ($urandom_range(1, 0) != 0) do_write(8'($urandom));
      nbytes = $urandom_range(3, 1);
      lbits  = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 8;
      for (int b = 0; b < 4; b++) f_mosi[b] = 8'($urandom);
      spi_frame(nbytes, lbits, $urandom_range(1, 0) != 0, 8'($urandom),
                $urandom_range(2, 0) == 0);
      nrd = $urandom_range(2, 0);
      for (int k = 0; k < nrd; k++) do_read();
      if ($urandom_range(3, 0) == 0) do_clear();
    end

    settled = 0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
